// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared raster timing constants for the 640x480@60 VGA mode.
//   vga_sync_gen uses these as parameter defaults. pixel_gen imports the same
//   active-area limits from here.
//   Contents: H_*/V_* porch/sync/active widths, derived totals and sync
//   window bounds, the sync polarity, the counter width and a small window
//   helper function.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int unsigned CNT_W    = 32'd10;

    localparam int unsigned H_ACTIVE = 32'd640;
    localparam int unsigned H_FP     = 32'd16;
    localparam int unsigned H_SYNC   = 32'd96;
    localparam int unsigned H_BP     = 32'd48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 32'd480;
    localparam int unsigned V_FP     = 32'd10;
    localparam int unsigned V_SYNC   = 32'd2;
    localparam int unsigned V_BP     = 32'd33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync windows are half-open: [start, end)
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    // 0 = active-low sync, the 640x480 standard
    localparam logic SYNC_POL = 1'b0;

    // Unsigned half-open window test used for both sync decodes
    function automatic logic in_window(
        input logic [9:0] cnt,
        input logic [9:0] lo,
        input logic [9:0] hi
    );
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// -----------------------------------------------------------------------------
// vga_wrap_counter
//   10-bit modulo counter: counts 0..MAX while en is high, then returns to 0.
//   Ports:
//     clk_d  in   pixel clock
//     rst_n  in   asynchronous active-low reset (count returns to 0)
//     en     in   advance enable
//     cnt    out  current count (registered)
//     wrap   out  high on the cycle where the count is at MAX and en is high,
//                 i.e. the count returns to 0 on the next edge
// -----------------------------------------------------------------------------
module vga_wrap_counter #(
    parameter int unsigned MAX = 32'd799
) (
    input  logic       clk_d,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] cnt,
    output logic       wrap
);

    localparam logic [9:0] MAX_C = 10'(MAX);

    logic [9:0] cnt_q;
    logic [9:0] cnt_d;
    logic       at_max_s;

    assign at_max_s = (cnt_q == MAX_C);

    // Next count: hold, increment, or wrap to zero at MAX
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (at_max_s) begin
                cnt_d = 10'd0;
            end else begin
                cnt_d = cnt_q + 10'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 10'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = en && at_max_s;

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//   Raster timing generator. Two chained wrap counters walk (h_cnt, v_cnt)
//   over the full raster. Every output is a register fed from a decode of the
//   counters, so all outputs carry the same 1-cycle latency and stay aligned
//   with each other.
//   Ports:
//     clk_d       in   pixel clock, counters advance every edge
//     rst_n       in   asynchronous active-low reset
//     hsync       out  horizontal sync (SYNC_POL_P when active)
//     vsync       out  vertical sync, whole lines (SYNC_POL_P when active)
//     video_on    out  inside the visible area
//     pixel_x     out  current column 0..H_TOTAL-1
//     pixel_y     out  current row 0..V_TOTAL-1
//     line_tick   out  pulse on last pixel of each line
//     frame_tick  out  pulse on last pixel of each frame
//     frame_cnt   out  frame counter, modulo 256, steps with frame_tick
// -----------------------------------------------------------------------------
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE_P = H_ACTIVE,
    parameter int unsigned H_FP_P     = H_FP,
    parameter int unsigned H_SYNC_P   = H_SYNC,
    parameter int unsigned H_BP_P     = H_BP,
    parameter int unsigned V_ACTIVE_P = V_ACTIVE,
    parameter int unsigned V_FP_P     = V_FP,
    parameter int unsigned V_SYNC_P   = V_SYNC,
    parameter int unsigned V_BP_P     = V_BP,
    parameter logic        SYNC_POL_P = SYNC_POL
) (
    input  logic       clk_d,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_tick,
    output logic       frame_tick,
    output logic [7:0] frame_cnt
);

    // Totals must fit the 10-bit counters (<= 1024)
    localparam int unsigned H_TOTAL_P = H_ACTIVE_P + H_FP_P + H_SYNC_P + H_BP_P;
    localparam int unsigned V_TOTAL_P = V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P;

    localparam logic [9:0] H_ACT_C = 10'(H_ACTIVE_P);
    localparam logic [9:0] H_SS_C  = 10'(H_ACTIVE_P + H_FP_P);
    localparam logic [9:0] H_SE_C  = 10'(H_ACTIVE_P + H_FP_P + H_SYNC_P);
    localparam logic [9:0] V_ACT_C = 10'(V_ACTIVE_P);
    localparam logic [9:0] V_SS_C  = 10'(V_ACTIVE_P + V_FP_P);
    localparam logic [9:0] V_SE_C  = 10'(V_ACTIVE_P + V_FP_P + V_SYNC_P);

    logic [9:0] h_cnt_s;
    logic [9:0] v_cnt_s;
    logic       h_wrap_s;
    logic       v_wrap_s;

    logic       hsync_q,      hsync_d;
    logic       vsync_q,      vsync_d;
    logic       video_on_q,   video_on_d;
    logic [9:0] pixel_x_q,    pixel_x_d;
    logic [9:0] pixel_y_q,    pixel_y_d;
    logic       line_tick_q,  line_tick_d;
    logic       frame_tick_q, frame_tick_d;
    logic [7:0] frame_cnt_q,  frame_cnt_d;

    vga_wrap_counter #(
        .MAX (H_TOTAL_P - 32'd1)
    ) u_h_cnt (
        .clk_d (clk_d),
        .rst_n (rst_n),
        .en    (1'b1),
        .cnt   (h_cnt_s),
        .wrap  (h_wrap_s)
    );

    // v advances only at end of line, so its wrap marks the last pixel of the frame
    vga_wrap_counter #(
        .MAX (V_TOTAL_P - 32'd1)
    ) u_v_cnt (
        .clk_d (clk_d),
        .rst_n (rst_n),
        .en    (h_wrap_s),
        .cnt   (v_cnt_s),
        .wrap  (v_wrap_s)
    );

    // Output decode from the current counter position
    always_comb begin
        pixel_x_d    = h_cnt_s;
        pixel_y_d    = v_cnt_s;
        video_on_d   = (h_cnt_s < H_ACT_C) && (v_cnt_s < V_ACT_C);
        hsync_d      = in_window(h_cnt_s, H_SS_C, H_SE_C) ? SYNC_POL_P : ~SYNC_POL_P;
        vsync_d      = in_window(v_cnt_s, V_SS_C, V_SE_C) ? SYNC_POL_P : ~SYNC_POL_P;
        line_tick_d  = h_wrap_s;
        frame_tick_d = v_wrap_s;
        frame_cnt_d  = frame_cnt_q;
        if (v_wrap_s) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Output registers; sync lines reset to their inactive level
    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q      <= ~SYNC_POL_P;
            vsync_q      <= ~SYNC_POL_P;
            video_on_q   <= 1'b0;
            pixel_x_q    <= 10'd0;
            pixel_y_q    <= 10'd0;
            line_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            video_on_q   <= video_on_d;
            pixel_x_q    <= pixel_x_d;
            pixel_y_q    <= pixel_y_d;
            line_tick_q  <= line_tick_d;
            frame_tick_q <= frame_tick_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = video_on_q;
    assign pixel_x    = pixel_x_q;
    assign pixel_y    = pixel_y_q;
    assign line_tick  = line_tick_q;
    assign frame_tick = frame_tick_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//   Three instances share one clock: A uses the full 640x480 timing, B the
//   full horizontal timing with a short vertical raster, C the tiny 4/1/1/1 by
//   3/1/1/1 raster for frame counter wrap. Each instance has its own reset.
//   Expected outputs come from an arithmetic model: after k clock edges out
//   of reset, the outputs describe raster position n = k-1.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

    localparam int  HA [3] = '{640, 640, 4};
    localparam int  HF [3] = '{16,  16,  1};
    localparam int  HS [3] = '{96,  96,  1};
    localparam int  HB [3] = '{48,  48,  1};
    localparam int  VA [3] = '{480, 4,   3};
    localparam int  VF [3] = '{10,  1,   1};
    localparam int  VS [3] = '{2,   2,   1};
    localparam int  VB [3] = '{33,  1,   1};
    localparam logic POL   = 1'b0;

    logic       clk = 1'b0;
    logic [2:0] rst_v = 3'b000;
    logic       chk_en = 1'b0;
    int         k_v [3] = '{0, 0, 0};
    int         n_tests = 0;
    int         n_fail  = 0;

    logic       hs_o [3];
    logic       vs_o [3];
    logic       vo_o [3];
    logic [9:0] px_o [3];
    logic [9:0] py_o [3];
    logic       lt_o [3];
    logic       ft_o [3];
    logic [7:0] fc_o [3];
    logic [32:0] obs [3];

    always #5 clk = ~clk;

    vga_sync_gen u_a (
        .clk_d(clk), .rst_n(rst_v[0]), .hsync(hs_o[0]), .vsync(vs_o[0]),
        .video_on(vo_o[0]), .pixel_x(px_o[0]), .pixel_y(py_o[0]),
        .line_tick(lt_o[0]), .frame_tick(ft_o[0]), .frame_cnt(fc_o[0])
    );

    vga_sync_gen #(
        .H_ACTIVE_P(HA[1]), .H_FP_P(HF[1]), .H_SYNC_P(HS[1]), .H_BP_P(HB[1]),
        .V_ACTIVE_P(VA[1]), .V_FP_P(VF[1]), .V_SYNC_P(VS[1]), .V_BP_P(VB[1]),
        .SYNC_POL_P(POL)
    ) u_b (
        .clk_d(clk), .rst_n(rst_v[1]), .hsync(hs_o[1]), .vsync(vs_o[1]),
        .video_on(vo_o[1]), .pixel_x(px_o[1]), .pixel_y(py_o[1]),
        .line_tick(lt_o[1]), .frame_tick(ft_o[1]), .frame_cnt(fc_o[1])
    );

    vga_sync_gen #(
        .H_ACTIVE_P(HA[2]), .H_FP_P(HF[2]), .H_SYNC_P(HS[2]), .H_BP_P(HB[2]),
        .V_ACTIVE_P(VA[2]), .V_FP_P(VF[2]), .V_SYNC_P(VS[2]), .V_BP_P(VB[2]),
        .SYNC_POL_P(POL)
    ) u_c (
        .clk_d(clk), .rst_n(rst_v[2]), .hsync(hs_o[2]), .vsync(vs_o[2]),
        .video_on(vo_o[2]), .pixel_x(px_o[2]), .pixel_y(py_o[2]),
        .line_tick(lt_o[2]), .frame_tick(ft_o[2]), .frame_cnt(fc_o[2])
    );

    for (genvar g = 0; g < 3; g++) begin : g_obs
        assign obs[g] = {hs_o[g], vs_o[g], vo_o[g], px_o[g], py_o[g],
                         lt_o[g], ft_o[g], fc_o[g]};
    end

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected packed outputs of instance idx after k edges out of reset
    function automatic logic [32:0] model(input logic rst_low, input int k, input int idx);
        int ht, vt, n, x, y, fc;
        logic hs, vs, vo, lt, ft;
        if (rst_low || k == 0) begin
            return {~POL, ~POL, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 8'd0};
        end
        ht = HA[idx] + HF[idx] + HS[idx] + HB[idx];
        vt = VA[idx] + VF[idx] + VS[idx] + VB[idx];
        n  = k - 1;
        x  = n % ht;
        y  = (n / ht) % vt;
        fc = (k / (ht * vt)) % 256;
        hs = (x >= HA[idx] + HF[idx] && x < HA[idx] + HF[idx] + HS[idx]) ? POL : ~POL;
        vs = (y >= VA[idx] + VF[idx] && y < VA[idx] + VF[idx] + VS[idx]) ? POL : ~POL;
        vo = (x < HA[idx]) && (y < VA[idx]);
        lt = (x == ht - 1);
        ft = lt && (y == vt - 1);
        return {hs, vs, vo, 10'(x), 10'(y), lt, ft, 8'(fc)};
    endfunction

    // Edges seen since each instance left reset
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_v[i]) k_v[i] <= 0;
            else           k_v[i] <= k_v[i] + 1;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("inst%0d_k%0d", i, k_v[i]), {31'd0, obs[i]},
                      {31'd0, model(!rst_v[i], k_v[i], i)});
            end
        end
    end

    // Independent width checks: hsync low run on A, vsync low run on B
    int hs_run = 0;
    int vs_run = 0;
    always @(negedge clk) begin
        if (!rst_v[0]) begin
            hs_run <= 0;
        end else if (hs_o[0] == POL) begin
            hs_run <= hs_run + 1;
        end else begin
            if (hs_run != 0) check("a_hsync_width", 64'(hs_run), 64'd96);
            hs_run <= 0;
        end
        if (!rst_v[1]) begin
            vs_run <= 0;
        end else if (vs_o[1] == POL) begin
            vs_run <= vs_run + 1;
        end else begin
            if (vs_run != 0) check("b_vsync_width", 64'(vs_run), 64'd1600);
            vs_run <= 0;
        end
    end

    // Frame counter wrap on C: 255 just before, 0 with frame_tick on the 256th frame edge
    always @(negedge clk) begin
        if (rst_v[2] && k_v[2] == 256 * 42 - 1) check("c_cnt_255", 64'(fc_o[2]), 64'd255);
        if (rst_v[2] && k_v[2] == 256 * 42)
            check("c_frame_wrap", {55'd0, ft_o[2], fc_o[2]}, {55'd0, 1'b1, 8'd0});
    end

    // Async reset mid-cycle: outputs must be at reset values before the next edge
    task automatic async_reset(input int i, input int hold);
        #2;
        rst_v[i] = 1'b0;
        #1;
        check($sformatf("async_rst_inst%0d", i), {31'd0, obs[i]}, {31'd0, model(1'b1, 0, i)});
        repeat (hold) @(negedge clk);
        #2;
        rst_v[i] = 1'b1;
    endtask

    initial begin
        logic found;
        rst_v = 3'b000;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        rst_v = 3'b111;

        // Run A to (300,30) and reset it there
        found = 1'b0;
        for (int c = 0; c < 40000 && !found; c++) begin
            @(negedge clk);
            if (px_o[0] == 10'd300 && py_o[0] == 10'd30) found = 1'b1;
        end
        check("a_reach_300_30", {63'd0, found}, 64'd1);
        async_reset(0, 3);
        @(posedge clk);
        #1;
        check("a_restart_xy", {44'd0, px_o[0], py_o[0]}, 64'd0);
        repeat (1000) @(negedge clk);

        // Random async resets on random instances
        for (int r = 0; r < 8; r++) begin
            int inst;
            inst = int'($urandom_range(2, 0));
            repeat ($urandom_range(2000, 20)) @(negedge clk);
            async_reset(inst, int'($urandom_range(4, 1)));
        end
        repeat (500) @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
